imm_decode_stage: RTL and testbench

Registered immediate-generation stage between fetch and execute of the pipelined RISC-V core. Accepts one instruction per cycle over a valid/ready handshake, decodes the immediate for every RV32I/RV64I base format, and presents it one cycle later together with a format code and an illegal flag. Parametrised in datapath width. A two-entry skid buffer keeps `in_ready` a registered signal, so back-pressure never forms a combinational path to fetch. Flush support lets the hazard unit squash in-flight instructions.

---
 rtl/imm_decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate decode stage with a two-entry skid buffer (output register + skid register).
// Optional feature macro: IMMDEC_CSR_EN enables decode of SYSTEM-opcode immediates (CSR zimm / ECALL-class I-type).
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSR   = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Handshake: a beat transfers on a rising edge where valid and ready are both high;
  // producers hold data stable while valid is high and ready is low.

  logic [31:0]     imm32;
  logic            sign_ext;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [2:0]      funct3;

  assign funct3 = in_inst[14:12];

  // imm32 holds the immediate with its sign bit at [31]; widening happens once below.
  always_comb begin
    imm32       = '0;
    sign_ext    = 1'b1;
    dec_fmt     = FMT_R;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        imm32   = {in_inst[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      OP_JAL: begin
        imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      OP_JALR, OP_LOAD, OP_FENCE: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_fmt = FMT_I;
      end
      OP_STORE: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec_fmt = FMT_S;
      end
      OP_BRANCH: begin
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          sign_ext = 1'b0;
          dec_fmt  = FMT_SHAMT;
          if (XLEN == 64) begin
            imm32 = {26'b0, in_inst[25:20]};
          end else begin
            imm32       = {27'b0, in_inst[24:20]};
            dec_illegal = in_inst[25];
          end
        end else begin
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
          dec_fmt = FMT_I;
        end
      end
      OP_REG: begin
        dec_fmt = FMT_R;
      end
`ifdef IMMDEC_CSR_EN
      OP_SYSTEM: begin
        if (funct3 != 3'b000) begin
          sign_ext = 1'b0;
          imm32    = {27'b0, in_inst[19:15]};
          dec_fmt  = FMT_CSR;
        end else begin
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
          dec_fmt = FMT_I;
        end
      end
`else
      OP_SYSTEM: begin
        dec_illegal = 1'b1;
      end
`endif
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
    dec_imm       = {XLEN{imm32[31] & sign_ext}};
    dec_imm[31:0] = imm32;
  end

  logic            skid_valid;
  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic            skid_illegal;
  logic            accept;

  assign accept = in_valid & in_ready;

  // in_ready is kept as its own flop (the complement of the next skid occupancy) so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_fmt      <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_inst    <= '0;
      skid_pc      <= '0;
      skid_imm     <= '0;
      skid_fmt     <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_inst    <= skid_inst;
        out_pc      <= skid_pc;
        out_imm     <= skid_imm;
        out_fmt     <= skid_fmt;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
        in_ready    <= 1'b1;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_inst    <= in_inst;
        out_pc      <= in_pc;
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_illegal <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_inst    <= in_inst;
      skid_pc      <= in_pc;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_illegal <= dec_illegal;
      in_ready     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances driven in lockstep, scoreboard plus directed checks.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        r64_in_ready, o64_valid, o64_ill;
  logic [31:0] o64_inst;
  logic [63:0] o64_pc, o64_imm;
  logic [2:0]  o64_fmt;

  logic        r32_in_ready, o32_valid, o32_ill;
  logic [31:0] o32_inst;
  logic [31:0] o32_pc, o32_imm;
  logic [2:0]  o32_fmt;

  int total = 0;
  int bad   = 0;

  // entry: {inst[31:0], pc[63:0], imm[63:0], fmt[2:0], illegal}
  logic [163:0] exp_q64[$];
  logic [163:0] exp_q32[$];

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(o64_valid), .out_ready(out_ready), .out_inst(o64_inst), .out_pc(o64_pc),
    .out_imm(o64_imm), .out_fmt(o64_fmt), .out_illegal(o64_ill)
  );

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(o32_valid), .out_ready(out_ready), .out_inst(o32_inst), .out_pc(o32_pc),
    .out_imm(o32_imm), .out_fmt(o32_fmt), .out_illegal(o32_ill)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // reference decoder: returns {imm[63:0], fmt[2:0], illegal}
  function automatic logic [67:0] model(input logic [31:0] i, input bit x64);
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    imm = '0; fmt = 3'd0; ill = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin imm = {{32{i[31]}}, i[31:12], 12'h000}; fmt = 3'd4; end
      7'h6f: begin imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; fmt = 3'd5; end
      7'h67, 7'h03, 7'h0f: begin imm = {{52{i[31]}}, i[31:20]}; fmt = 3'd1; end
      7'h23: begin imm = {{52{i[31]}}, i[31:25], i[11:7]}; fmt = 3'd2; end
      7'h63: begin imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; fmt = 3'd3; end
      7'h13: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          fmt = 3'd6;
          if (x64) imm = {58'b0, i[25:20]};
          else begin imm = {59'b0, i[24:20]}; ill = i[25]; end
        end else begin
          imm = {{52{i[31]}}, i[31:20]}; fmt = 3'd1;
        end
      end
      7'h33: fmt = 3'd0;
      7'h73: begin
`ifdef IMMDEC_CSR_EN
        if (i[14:12] != 3'd0) begin imm = {59'b0, i[19:15]}; fmt = 3'd7; end
        else begin imm = {{52{i[31]}}, i[31:20]}; fmt = 3'd1; end
`else
        ill = 1'b1;
`endif
      end
      default: ill = 1'b1;
    endcase
    if (!x64) imm[63:32] = 32'b0;
    return {imm, fmt, ill};
  endfunction

  // scoreboard: push on accepted beats, pop when the output is consumed, check stall stability
  logic         prev_stall = 1'b0;
  logic [163:0] prev_out   = '0;

  always @(negedge clk) begin
    logic [163:0] obs64, obs32, e;
    obs64 = {o64_inst, o64_pc, o64_imm, o64_fmt, o64_ill};
    obs32 = {o32_inst, 32'b0, o32_pc, 32'b0, o32_imm, o32_fmt, o32_ill};
    if (prev_stall && o64_valid) begin
      total++;
      if (obs64 !== prev_out) begin
        $display("FAIL stall_stable got=%h want=%h", obs64, prev_out);
        bad++;
      end
    end
    if (!rst_n || flush) begin
      exp_q64.delete();
      exp_q32.delete();
      prev_stall = 1'b0;
    end else begin
      if (o64_valid && out_ready) begin
        total++;
        if (exp_q64.size() == 0) begin
          $display("FAIL sb64_unexpected got=%h want=none", obs64);
          bad++;
        end else begin
          e = exp_q64.pop_front();
          if (obs64 !== e) begin
            $display("FAIL sb64 got=%h want=%h", obs64, e);
            bad++;
          end
        end
      end
      if (o32_valid && out_ready) begin
        total++;
        if (exp_q32.size() == 0) begin
          $display("FAIL sb32_unexpected got=%h want=none", obs32);
          bad++;
        end else begin
          e = exp_q32.pop_front();
          if (obs32 !== e) begin
            $display("FAIL sb32 got=%h want=%h", obs32, e);
            bad++;
          end
        end
      end
      if (in_valid && r64_in_ready) exp_q64.push_back({in_inst, in_pc, model(in_inst, 1'b1)});
      if (in_valid && r32_in_ready) exp_q32.push_back({in_inst, 32'b0, in_pc[31:0], model(in_inst, 1'b0)});
      prev_stall = o64_valid && !out_ready;
    end
    prev_out = obs64;
  end

  // driver tasks
  task automatic drive_beat(input logic [31:0] inst, input logic [63:0] pc);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (r64_in_ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      $display("FAIL beat_accept_timeout got=in_ready0 want=in_ready1");
      bad++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (exp_q64.size() == 0 && exp_q32.size() == 0 && !o64_valid && !o32_valid) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      $display("FAIL drain_timeout got=q%0d want=q0", exp_q64.size());
      bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o64_valid, o32_valid} !== 2'b00) begin
      $display("FAIL reset_out_valid got=%b want=00", {o64_valid, o32_valid}); bad++;
    end
    total++;
    if ({r64_in_ready, r32_in_ready} !== 2'b11) begin
      $display("FAIL reset_in_ready got=%b want=11", {r64_in_ready, r32_in_ready}); bad++;
    end
    total++;
    if ({o64_inst, o64_pc, o64_imm, o64_fmt, o64_ill} !== 164'd0) begin
      $display("FAIL reset_out64_fields got=%h want=0", {o64_inst, o64_pc, o64_imm, o64_fmt, o64_ill}); bad++;
    end
    total++;
    if ({o32_inst, o32_pc, o32_imm, o32_fmt, o32_ill} !== 100'd0) begin
      $display("FAIL reset_out32_fields got=%h want=0", {o32_inst, o32_pc, o32_imm, o32_fmt, o32_ill}); bad++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_itype();
    out_ready = 1'b1;
    drive_beat(32'hFFF00093, 64'h0000_0000_0000_1000);
    total++;
    if ({o32_valid, o32_imm, o32_fmt, o32_ill} !== {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0}) begin
      $display("FAIL addi32 got=%b_%h_%0d_%b want=1_ffffffff_1_0", o32_valid, o32_imm, o32_fmt, o32_ill); bad++;
    end
    total++;
    if ({o64_imm, o64_fmt} !== {64'hFFFFFFFF_FFFFFFFF, 3'd1}) begin
      $display("FAIL addi64 got=%h_%0d want=ffffffffffffffff_1", o64_imm, o64_fmt); bad++;
    end
  endtask

  task automatic test_lui_shamt();
    out_ready = 1'b1;
    drive_beat(32'h800000B7, 64'h0000_0000_0000_1004);
    total++;
    if ({o64_imm, o64_fmt} !== {64'hFFFFFFFF_80000000, 3'd4}) begin
      $display("FAIL lui64 got=%h_%0d want=ffffffff80000000_4", o64_imm, o64_fmt); bad++;
    end
    total++;
    if (o32_imm !== 32'h80000000) begin
      $display("FAIL lui32 got=%h want=80000000", o32_imm); bad++;
    end
    drive_beat(32'h03F09093, 64'h0000_0000_0000_1008);
    total++;
    if ({o64_imm, o64_fmt, o64_ill} !== {64'd63, 3'd6, 1'b0}) begin
      $display("FAIL slli64 got=%h_%0d_%b want=3f_6_0", o64_imm, o64_fmt, o64_ill); bad++;
    end
    total++;
    if ({o32_imm, o32_fmt, o32_ill} !== {32'd31, 3'd6, 1'b1}) begin
      $display("FAIL slli32_illegal got=%h_%0d_%b want=1f_6_1", o32_imm, o32_fmt, o32_ill); bad++;
    end
  endtask

  task automatic test_formats();
    logic [31:0] insts [3];
    logic [31:0] imms  [3];
    logic [2:0]  fmts  [3];
    insts = '{32'hFE000EE3, 32'h0080006F, 32'hFE112E23};
    imms  = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC};
    fmts  = '{3'd3, 3'd5, 3'd2};
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive_beat(insts[n], 64'h0000_0000_0000_2000 + 64'(4 * n));
      total++;
      if ({o32_imm, o32_fmt, o32_ill} !== {imms[n], fmts[n], 1'b0}) begin
        $display("FAIL format_%0d got=%h_%0d_%b want=%h_%0d_0", n, o32_imm, o32_fmt, o32_ill, imms[n], fmts[n]); bad++;
      end
    end
  endtask

  task automatic test_csr();
    out_ready = 1'b1;
    drive_beat(32'h7C02D073, 64'h0000_0000_0000_3000);
    total++;
`ifdef IMMDEC_CSR_EN
    if ({o32_imm, o32_fmt, o32_ill} !== {32'd5, 3'd7, 1'b0}) begin
      $display("FAIL csrrwi got=%h_%0d_%b want=5_7_0", o32_imm, o32_fmt, o32_ill); bad++;
    end
`else
    if ({o32_imm, o32_fmt, o32_ill} !== {32'd0, 3'd0, 1'b1}) begin
      $display("FAIL csrrwi got=%h_%0d_%b want=0_0_1", o32_imm, o32_fmt, o32_ill); bad++;
    end
`endif
    wait_drain();
  endtask

  // fills output register with A and skid with B while stalled; leaves C offered
  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = a; in_pc = 64'h4000;
    @(posedge clk); #1;
    total++;
    if ({o64_valid, o64_inst, r64_in_ready} !== {1'b1, a, 1'b1}) begin
      $display("FAIL fill_a got=%b_%h_%b want=1_%h_1", o64_valid, o64_inst, r64_in_ready, a); bad++;
    end
    in_inst = b; in_pc = 64'h4004;
    @(posedge clk); #1;
    total++;
    if ({o64_inst, r64_in_ready, r32_in_ready} !== {a, 1'b0, 1'b0}) begin
      $display("FAIL fill_b got=%h_%b%b want=%h_00", o64_inst, r64_in_ready, r32_in_ready, a); bad++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    fill_two(32'h00100093, 32'h00200113);
    in_inst = 32'h00300193; in_pc = 64'h4008;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if ({o64_valid, o64_inst, r64_in_ready} !== {1'b1, 32'h00100093, 1'b0}) begin
        $display("FAIL b2b_hold got=%b_%h_%b want=1_00100093_0", o64_valid, o64_inst, r64_in_ready); bad++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({o64_inst, r64_in_ready} !== {32'h00200113, 1'b1}) begin
      $display("FAIL b2b_skid_out got=%h_%b want=00200113_1", o64_inst, r64_in_ready); bad++;
    end
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (r64_in_ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin $display("FAIL b2b_c_accept got=0 want=1"); bad++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_flush();
    fill_two(32'h00500293, 32'h00600313);
    flush = 1'b1; in_inst = 32'h00700393; in_pc = 64'h5000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({o64_valid, o32_valid, r64_in_ready, r32_in_ready} !== 4'b0011) begin
      $display("FAIL flush_state got=%b want=0011", {o64_valid, o32_valid, r64_in_ready, r32_in_ready}); bad++;
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({o64_valid, o32_valid} !== 2'b00) begin
      $display("FAIL flush_no_ghost got=%b want=00", {o64_valid, o32_valid}); bad++;
    end
  endtask

  task automatic test_reset_mid_stall();
    fill_two(32'h00800413, 32'h00900493);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({o64_valid, o32_valid, r64_in_ready, r32_in_ready} !== 4'b0011) begin
      $display("FAIL reset_stall got=%b want=0011", {o64_valid, o32_valid, r64_in_ready, r32_in_ready}); bad++;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o64_valid !== 1'b0) begin
      $display("FAIL reset_stall_no_ghost got=%b want=0", o64_valid); bad++;
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [12];
    logic [31:0] r;
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h0f, 7'h23, 7'h63, 7'h13, 7'h33, 7'h73, 7'h5b};
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      in_inst   = {r[31:7], opcs[$urandom_range(0, 11)]};
      in_pc     = {$urandom(), $urandom()};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_itype();
    test_lui_shamt();
    test_formats();
    test_csr();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
